decode_writeback: RTL and testbench
===================================

// Module: decode_writeback
// PURPOSE
//  Y86-64 SEQ decode/write-back stage: 15x64-bit register file with two combinational read
//  ports (valA, valB) and two write ports (E from execute, M from memory stage).
//  Derives srcA/srcB/dstE/dstM from icode/rA/rB/cnd. Feeds execute and memory stages.
//  Tracks processor status and the retired-instruction count.
// PARAMETERS
//  NREG    15  architectural registers; IDs 0..14, ID 4'hF = RNONE
//  CNT_W   32  width of retired-instruction counter
// PORTS
//  clock        in   1      system clock, all state on posedge
//  reset        in   1      synchronous, active-high
//  icode        in   4      instruction code of the current instruction
//  rA           in   4      register field A
//  rB           in   4      register field B
//  cnd          in   1      condition result from execute (gates cmovXX)
//  stat_in      in   2      fetch/mem status: 1=AOK 2=HLT 3=ADR 4->0=INS (enc: 0 INS,1 AOK,2 HLT,3 ADR)
//  valE         in   64     ALU result
//  valM         in   64     memory read data
//  valA         out  64     R[srcA], 0 when srcA=RNONE
//  valB         out  64     R[srcB], 0 when srcB=RNONE
//  stat         out  2      registered processor status
//  halted       out  1      1 once in HALTED state
//  retired      out  CNT_W  count of committed instructions
// BEHAVIOUR
//  Reset (sync): all R[0..14]=0, stat=AOK(1), halted=0, retired=0; FSM -> RUN.
//  srcA: rA for cmovXX(2), rmmovq(4), OPq(6), pushq(A); RSP(4) for popq(B), ret(9); else F.
//  srcB: rB for rmmovq, mrmovq(5), OPq; RSP for pushq, popq, call(8), ret; else F.
//  dstE: rB for irmovq(3), OPq, cmovXX when cnd=1 (cnd=0 -> F); RSP for push/pop/call/ret.
//  dstM: rA for mrmovq, popq; else F.
//  Reads combinational, zero latency; reads see pre-edge values (no bypass unless macro).
//  Writes at posedge when FSM=RUN and stat_in=AOK: R[dstE]<=valE, R[dstM]<=valM.
//  dstE==dstM (e.g. popq %rsp): M port wins, R=valM.
//  dst=F: no write. Width: full 64-bit, no truncation.
//  FSM: RUN -> HALTED when stat_in!=AOK or icode=halt(0) (stat<=HLT for halt, else stat_in).
//       HALTED: sticky until reset; all writes and counter frozen; valA/valB still readable.
//  Illegal icode (>B) in RUN: stat<=INS, -> HALTED, no write.
//  retired: +1 per posedge in RUN with successful commit (incl. nop, cmov cnd=0,
//    jXX, halt itself); wraps 2^CNT_W-1 -> 0.
//  Reset asserted in same cycle as a write: reset wins, no write, regs=0.
// CONFIGURATION
//  WB_BYPASS_EN defined: if srcA/srcB equals this cycle's dstM (priority) or dstE and
//    the write is enabled, valA/valB return valM/valE combinationally.
//  Not defined: pure register-file reads, pre-edge values only.
// TESTING
//  reset; irmovq rB=2 valE=0x1234 -> next cycle R2=0x1234, retired=1, stat=AOK.
//  OPq rA=2 rB=3, R2=5 R3=7 -> valA=5 valB=7; valE=0xC written to R3.
//  popq rA=4, valE=0x108, valM=0xDEAD -> R4=0xDEAD (M priority); dstE==dstM.
//  cmovXX rA=1 rB=6 cnd=0 valE=9 -> R6 unchanged, retired still +1.
//  icode=0 -> stat=HLT, halted=1; following irmovq rB=1 valE=5 -> R1 unchanged,
//    retired frozen; reset -> all zero, halted=0.
//  WB_BYPASS_EN: mrmovq rA=5 valM=0x77 while srcB=5 -> valB=0x77 same cycle; without macro old R5.

Source files
------------

// File: rtl/decode_writeback.sv
// Y86-64 SEQ decode/write-back: 15x64 register file, src/dst decode, status FSM, retire counter.
// Latency: reads combinational (0 cycles); writes, status and counter update on the next posedge.
// Backpressure: none; one instruction per cycle. Optional WB_BYPASS_EN forwards valM/valE to reads.
module decode_writeback #(
    parameter int NREG  = 15,
    parameter int CNT_W = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [3:0]       icode,
    input  logic [3:0]       rA,
    input  logic [3:0]       rB,
    input  logic             cnd,
    input  logic [1:0]       stat_in,
    input  logic [63:0]      valE,
    input  logic [63:0]      valM,
    output logic [63:0]      valA,
    output logic [63:0]      valB,
    output logic [1:0]       stat,
    output logic             halted,
    output logic [CNT_W-1:0] retired
);

    localparam logic [3:0] RNONE   = 4'hF;
    localparam logic [3:0] RSP     = 4'h4;
    localparam logic [3:0] I_HALT  = 4'h0;
    localparam logic [3:0] I_CMOV  = 4'h2;
    localparam logic [3:0] I_IRMOV = 4'h3;
    localparam logic [3:0] I_RMMOV = 4'h4;
    localparam logic [3:0] I_MRMOV = 4'h5;
    localparam logic [3:0] I_OP    = 4'h6;
    localparam logic [3:0] I_CALL  = 4'h8;
    localparam logic [3:0] I_RET   = 4'h9;
    localparam logic [3:0] I_PUSH  = 4'hA;
    localparam logic [3:0] I_POP   = 4'hB;

    localparam logic [1:0] S_INS = 2'd0;
    localparam logic [1:0] S_AOK = 2'd1;
    localparam logic [1:0] S_HLT = 2'd2;

    typedef enum logic [0:0] {RUN = 1'b0, HALTED = 1'b1} state_t;

    state_t      state;
    logic [63:0] regs [NREG];
    logic [3:0]  srcA, srcB, dstE, dstM;
    logic        legal, commit, wrE, wrM;
    logic [63:0] rfA, rfB;

    always_comb begin
        srcA = RNONE;
        srcB = RNONE;
        dstE = RNONE;
        dstM = RNONE;
        case (icode)
            I_CMOV:  begin srcA = rA; dstE = cnd ? rB : RNONE; end
            I_IRMOV: dstE = rB;
            I_RMMOV: begin srcA = rA; srcB = rB; end
            I_MRMOV: begin srcB = rB; dstM = rA; end
            I_OP:    begin srcA = rA; srcB = rB; dstE = rB; end
            I_CALL:  begin srcB = RSP; dstE = RSP; end
            I_RET:   begin srcA = RSP; srcB = RSP; dstE = RSP; end
            I_PUSH:  begin srcA = rA; srcB = RSP; dstE = RSP; end
            I_POP:   begin srcA = RSP; srcB = RSP; dstE = RSP; dstM = rA; end
            default: ;
        endcase
    end

    assign legal  = (icode <= I_POP);
    assign commit = (state == RUN) && (stat_in == S_AOK) && legal;
    assign wrE    = commit && (dstE != RNONE);
    assign wrM    = commit && (dstM != RNONE);

    assign rfA = (srcA == RNONE) ? 64'd0 : regs[srcA];
    assign rfB = (srcB == RNONE) ? 64'd0 : regs[srcB];

`ifdef WB_BYPASS_EN
    // M port has priority, matching the write-back ordering below.
    always_comb begin
        valA = rfA;
        valB = rfB;
        if (srcA != RNONE) begin
            if (wrM && srcA == dstM)      valA = valM;
            else if (wrE && srcA == dstE) valA = valE;
        end
        if (srcB != RNONE) begin
            if (wrM && srcB == dstM)      valB = valM;
            else if (wrE && srcB == dstE) valB = valE;
        end
    end
`else
    assign valA = rfA;
    assign valB = rfB;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) regs[i] <= 64'd0;
            state   <= RUN;
            stat    <= S_AOK;
            halted  <= 1'b0;
            retired <= '0;
        end else if (state == RUN) begin
            if (wrE) regs[dstE] <= valE;
            // Second assignment wins when dstE == dstM (popq %rsp).
            if (wrM) regs[dstM] <= valM;
            if (stat_in != S_AOK) begin
                state  <= HALTED;
                halted <= 1'b1;
                stat   <= stat_in;
            end else if (!legal) begin
                state  <= HALTED;
                halted <= 1'b1;
                stat   <= S_INS;
            end else begin
                retired <= retired + CNT_W'(1);
                if (icode == I_HALT) begin
                    state  <= HALTED;
                    halted <= 1'b1;
                    stat   <= S_HLT;
                end
            end
        end
    end

endmodule

// File: tb/tb_decode_writeback.sv
// Scoreboard bench for decode_writeback; narrow retire counter so wrap-around is reached.
module tb_decode_writeback;

    localparam int CW = 4;
`ifdef WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset;
    logic [3:0]    icode, rA, rB;
    logic          cnd;
    logic [1:0]    stat_in;
    logic [63:0]   valE, valM;
    logic [63:0]   valA, valB;
    logic [1:0]    stat;
    logic          halted;
    logic [CW-1:0] retired;

    decode_writeback #(.NREG(15), .CNT_W(CW)) dut (
        .clock(clock), .reset(reset), .icode(icode), .rA(rA), .rB(rB), .cnd(cnd),
        .stat_in(stat_in), .valE(valE), .valM(valM), .valA(valA), .valB(valB),
        .stat(stat), .halted(halted), .retired(retired)
    );

    always #5 clock = ~clock;

    typedef enum int {K_VALA, K_VALB, K_STAT, K_HALT, K_RET} kind_t;
    typedef struct {
        kind_t       kind;
        logic [63:0] exp;
        string       name;
    } chk_t;

    chk_t sbq[$];
    int   checks = 0;
    int   errors = 0;

    // Monitor: every negedge drains all expectations pushed for the current cycle.
    always @(negedge clock) begin
        while (sbq.size() > 0) begin
            chk_t c;
            logic [63:0] act;
            c = sbq.pop_front();
            case (c.kind)
                K_VALA:  act = valA;
                K_VALB:  act = valB;
                K_STAT:  act = {62'd0, stat};
                K_HALT:  act = {63'd0, halted};
                default: act = {{(64-CW){1'b0}}, retired};
            endcase
            checks++;
            if (act !== c.exp) begin
                errors++;
                $display("FAIL %s: got 0x%0h expected 0x%0h", c.name, act, c.exp);
            end
        end
    end

    task automatic want(input kind_t k, input logic [63:0] e, input string n);
        chk_t c;
        c.kind = k;
        c.exp  = e;
        c.name = n;
        sbq.push_back(c);
    endtask

    task automatic wantRet(input int n, input string nm);
        want(K_RET, 64'(n % (1 << CW)), nm);
    endtask

    // Apply one instruction for the coming cycle.
    task automatic drive(input logic rst, input logic [3:0] ic, input logic [3:0] a,
                         input logic [3:0] b, input logic c, input logic [1:0] s,
                         input logic [63:0] e, input logic [63:0] m);
        @(posedge clock);
        #1;
        reset = rst; icode = ic; rA = a; rB = b; cnd = c; stat_in = s; valE = e; valM = m;
    endtask

    initial begin
        reset = 1'b1; icode = 4'h1; rA = 4'hF; rB = 4'hF; cnd = 1'b0;
        stat_in = 2'd1; valE = '0; valM = '0;

        drive(1, 4'h3, 4'hF, 4'h2, 0, 1, 64'h99, 0);         // write during reset
        drive(0, 4'h4, 4'h2, 4'h2, 0, 1, 0, 0);
        want(K_VALA, 64'h0, "reset_wins_R2");
        want(K_VALB, 64'h0, "reset_valB");
        want(K_STAT, 64'd1, "reset_stat");
        want(K_HALT, 64'd0, "reset_halted");
        wantRet(0, "reset_retired");

        drive(0, 4'h3, 4'hF, 4'h2, 0, 1, 64'h1234, 0);       // irmovq -> R2
        want(K_VALA, 64'h0, "irmovq_srcA_none");
        wantRet(1, "ret1");
        drive(0, 4'h4, 4'h2, 4'h2, 0, 1, 0, 0);
        want(K_VALA, 64'h1234, "irmovq_R2");
        want(K_STAT, 64'd1, "stat_aok");
        wantRet(2, "ret2");

        drive(0, 4'h3, 4'hF, 4'h2, 0, 1, 64'd5, 0);
        drive(0, 4'h3, 4'hF, 4'h3, 0, 1, 64'd7, 0);
        drive(0, 4'h6, 4'h2, 4'h3, 0, 1, 64'hC, 0);          // OPq
        want(K_VALA, 64'd5, "opq_valA");
        want(K_VALB, BYP ? 64'hC : 64'd7, "opq_valB");
        drive(0, 4'h4, 4'h3, 4'h2, 0, 1, 0, 0);
        want(K_VALA, 64'hC, "opq_R3");
        want(K_VALB, 64'd5, "opq_R2_kept");

        drive(0, 4'h3, 4'hF, 4'h4, 0, 1, 64'h100, 0);        // rsp = 0x100
        drive(0, 4'hA, 4'h2, 4'hF, 0, 1, 64'hF8, 0);         // pushq
        want(K_VALA, 64'd5, "push_valA");
        want(K_VALB, BYP ? 64'hF8 : 64'h100, "push_valB_rsp");
        drive(0, 4'hB, 4'h4, 4'hF, 0, 1, 64'h108, 64'hDEAD); // popq %rsp
        want(K_VALA, BYP ? 64'hDEAD : 64'hF8, "pop_valA_rsp");
        drive(0, 4'h4, 4'h4, 4'h4, 0, 1, 0, 0);
        want(K_VALA, 64'hDEAD, "pop_m_priority");

        drive(0, 4'h2, 4'h1, 4'h6, 0, 1, 64'd9, 0);          // cmov cnd=0
        want(K_VALA, 64'h0, "cmov_valA");
        drive(0, 4'h4, 4'h6, 4'h1, 0, 1, 0, 0);
        want(K_VALA, 64'h0, "cmov_nc_R6");
        wantRet(12, "cmov_nc_retired");
        drive(0, 4'h2, 4'h2, 4'h6, 1, 1, 64'h5A, 0);         // cmov cnd=1
        drive(0, 4'h4, 4'h6, 4'hF, 0, 1, 0, 0);
        want(K_VALA, 64'h5A, "cmov_c_R6");
        want(K_VALB, 64'h0, "rnone_valB");

        drive(0, 4'h3, 4'hF, 4'h7, 0, 1, 64'hFEDC_BA98_7654_3210, 0);
        drive(0, 4'h5, 4'h8, 4'h7, 0, 1, 0, 64'h77);         // mrmovq -> R8
        want(K_VALB, 64'hFEDC_BA98_7654_3210, "full64_R7");
        wantRet(16, "retired_wrap");
        drive(0, 4'h5, 4'h5, 4'h5, 0, 1, 0, 64'h77);         // srcB == dstM
        want(K_VALB, BYP ? 64'h77 : 64'h0, "bypass_valB");
        drive(0, 4'h4, 4'h8, 4'h5, 0, 1, 0, 0);
        want(K_VALA, 64'h77, "mrmov_R8");
        want(K_VALB, 64'h77, "mrmov_R5");

        drive(0, 4'h7, 4'hF, 4'hF, 0, 1, 0, 0);              // jXX
        wantRet(19, "jxx_pre");
        drive(0, 4'h0, 4'hF, 4'hF, 0, 1, 0, 0);              // halt
        wantRet(20, "halt_pre");
        want(K_HALT, 64'd0, "halt_pre_halted");
        drive(0, 4'h3, 4'hF, 4'h1, 0, 1, 64'd5, 0);
        want(K_STAT, 64'd2, "halt_stat");
        want(K_HALT, 64'd1, "halt_halted");
        wantRet(21, "halt_counted");
        drive(0, 4'h4, 4'h1, 4'h5, 0, 1, 0, 0);
        want(K_VALA, 64'h0, "halted_no_write");
        want(K_VALB, 64'h77, "halted_readable");
        wantRet(21, "halted_frozen");

        drive(1, 4'h1, 4'hF, 4'hF, 0, 1, 0, 0);
        drive(0, 4'h4, 4'h5, 4'h3, 0, 1, 0, 0);
        want(K_VALA, 64'h0, "reset2_R5");
        want(K_VALB, 64'h0, "reset2_R3");
        want(K_STAT, 64'd1, "reset2_stat");
        want(K_HALT, 64'd0, "reset2_halted");
        wantRet(0, "reset2_retired");
        drive(0, 4'hC, 4'h0, 4'h0, 0, 1, 64'h55, 64'h55);    // illegal icode
        drive(0, 4'h1, 4'hF, 4'hF, 0, 1, 0, 0);
        want(K_STAT, 64'd0, "ins_stat");
        want(K_HALT, 64'd1, "ins_halted");
        wantRet(1, "ins_not_counted");

        drive(1, 4'h1, 4'hF, 4'hF, 0, 1, 0, 0);
        drive(0, 4'h3, 4'hF, 4'h9, 0, 3, 64'h55, 0);         // stat_in = ADR
        drive(0, 4'h4, 4'h9, 4'hF, 0, 1, 0, 0);
        want(K_STAT, 64'd3, "adr_stat");
        want(K_HALT, 64'd1, "adr_halted");
        want(K_VALA, 64'h0, "adr_no_write");
        wantRet(0, "adr_not_counted");

        @(posedge clock);
        #1;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: got %0d pending expected 0", sbq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
